i2s_rx_unit: RTL and testbench



---
 rtl/i2s_rx_unit_pkg.sv | 16 +
 rtl/i2s_rx_unit_sync.sv | 44 ++++
 rtl/i2s_rx_unit.sv | 156 +++++++++++++++
 tb/tb_i2s_rx_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_unit_pkg.sv
// Shared constants and types for the I2S receiver: slot geometry and the
// receive FSM state encoding.
package i2s_rx_unit_pkg;

    localparam int I2S_DATA_W      = 24;
    localparam int I2S_SLOT_W      = 32;
    localparam int I2S_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SYNC,
        RX_LEFT,
        RX_RIGHT
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_unit_sync.sv
// Brings sck/ws/sdo into the clk domain with equal delay and flags sck rises.
module i2s_rx_unit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_in,
    input  logic ws_in,
    input  logic sdo_in,
    output logic sck_rise,
    output logic ws_s,
    output logic sdo_s
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] ws_q;
    logic [SYNC_STAGES-1:0] sdo_q;
    logic                   sck_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q      <= '0;
            ws_q       <= '0;
            sdo_q      <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q[0] <= sck_in;
            ws_q[0]  <= ws_in;
            sdo_q[0] <= sdo_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_q[i] <= sck_q[i-1];
                ws_q[i]  <= ws_q[i-1];
                sdo_q[i] <= sdo_q[i-1];
            end
            sck_prev_q <= sck_q[SYNC_STAGES-1];
        end
    end

    // ws and sdo share the sck pipeline depth, so they are aligned with the rise
    assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign ws_s     = ws_q[SYNC_STAGES-1];
    assign sdo_s    = sdo_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_unit.sv
// Philips I2S receiver: oversamples sck/ws/sdo on clk, deserialises MSB-first
// samples from fixed-width slots and emits each stereo frame with a valid strobe.
module i2s_rx_unit
    import i2s_rx_unit_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W,
    parameter int SLOT_W      = I2S_SLOT_W,
    parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_in,
    input  logic              sck_in,
    input  logic              ws_in,
    input  logic              sdo_in,
    output logic [DATA_W-1:0] audio_out_0,
    output logic [DATA_W-1:0] audio_out_1,
    output logic              valid_out,
    output logic              err_out
);

    localparam int                CNT_W     = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] SLOT_CNT  = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_W);

    logic sck_rise;
    logic ws_s;
    logic sdo_s;

    i2s_rx_unit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sck_in  (sck_in),
        .ws_in   (ws_in),
        .sdo_in  (sdo_in),
        .sck_rise(sck_rise),
        .ws_s    (ws_s),
        .sdo_s   (sdo_s)
    );

    i2s_rx_state_t     state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              ws_prev_q, ws_prev_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic [DATA_W-1:0] out0_q, out0_d;
    logic [DATA_W-1:0] out1_q, out1_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              boundary;
    logic [CNT_W-1:0]  cnt_inc;
    logic              data_bit;

    assign boundary = sck_rise && (ws_s != ws_prev_q);
    assign cnt_inc  = bit_cnt_q + 1'b1;
    assign data_bit = (cnt_inc != '0) && (cnt_inc <= DATA_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            ws_prev_q <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ws_prev_q <= ws_prev_d;
            left_q    <= left_d;
            right_q   <= right_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ws_prev_d = ws_prev_q;
        left_d    = left_q;
        right_d   = right_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        // ws history tracks every rise so a boundary is seen even straight after IDLE
        if (sck_rise) begin
            ws_prev_d = ws_s;
        end

        if (!enable_in) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    state_d = RX_SYNC;
                end
                RX_SYNC: begin
                    if (boundary && !ws_s) begin
                        state_d   = RX_LEFT;
                        bit_cnt_d = '0;
                    end
                end
                RX_LEFT, RX_RIGHT: begin
                    if (boundary) begin
                        bit_cnt_d = '0;
                        if (bit_cnt_q == LAST_CNT && state_q == RX_LEFT && ws_s) begin
                            state_d = RX_RIGHT;
                        end else if (bit_cnt_q == LAST_CNT && state_q == RX_RIGHT && !ws_s) begin
                            state_d = RX_LEFT;
                            out0_d  = left_q;
                            out1_d  = right_q;
                            valid_d = 1'b1;
                        end else begin
                            // a short slot ending on a left boundary resyncs immediately
                            err_d   = 1'b1;
                            state_d = ws_s ? RX_SYNC : RX_LEFT;
                        end
                    end else if (sck_rise) begin
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == SLOT_CNT) begin
                            err_d   = 1'b1;
                            state_d = RX_SYNC;
                        end else if (data_bit) begin
                            if (state_q == RX_LEFT) begin
                                left_d = {left_q[DATA_W-2:0], sdo_s};
                            end else begin
                                right_d = {right_q[DATA_W-2:0], sdo_s};
                            end
                        end
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    assign audio_out_0 = out0_q;
    assign audio_out_1 = out1_q;
    assign valid_out   = valid_q;
    assign err_out     = err_q;

endmodule

// File: tb/tb_i2s_rx_unit.sv
// Bench for i2s_rx_unit: an I2S transmitter model drives slots, a scoreboard
// queue holds the frames/errors each slot sequence must produce.
module tb_i2s_rx_unit;

    logic        clk;
    logic        rst_n;
    logic        enable_in;
    logic        sck_in;
    logic        ws_in;
    logic        sdo_in;
    logic [23:0] audio_out_0;
    logic [23:0] audio_out_1;
    logic        valid_out;
    logic        err_out;

    i2s_rx_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_in  (enable_in),
        .sck_in     (sck_in),
        .ws_in      (ws_in),
        .sdo_in     (sdo_in),
        .audio_out_0(audio_out_0),
        .audio_out_1(audio_out_1),
        .valid_out  (valid_out),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;   // 1 = frame, 2 = framing error
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;

    typedef struct {
        logic [23:0] l_in;
        logic [23:0] r_in;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int hook_bit = -1;
    int hook_kind = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Scoreboard: every valid/err strobe must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && (valid_out || err_out)) begin
            exp_t e;
            $display("event @%0d: valid=%0b err=%0b L=%h R=%h", cyc, valid_out, err_out,
                     audio_out_0, audio_out_1);
            chk("strobe_exclusive", 24'(valid_out & err_out), 24'h0);
            chk("latency", 24'(cyc - last_rise_cyc), 24'd3);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b, expected none",
                         valid_out, err_out);
            end else begin
                e = sb_q.pop_front();
                chk("event_kind", {22'h0, err_out, valid_out}, {22'h0, e.kind});
                if (e.kind == 2'd1) begin
                    chk("audio_out_0", audio_out_0, e.l);
                    chk("audio_out_1", audio_out_1, e.r);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] kind, input logic [23:0] l, input logic [23:0] r);
        exp_t e;
        e.kind = kind;
        e.l    = l;
        e.r    = r;
        sb_q.push_back(e);
    endtask

    task automatic do_hook(input logic [23:0] hold_l, input logic [23:0] hold_r);
        if (hook_kind == 1) begin
            enable_in = 1'b0;
            repeat (10) @(negedge clk);
            enable_in = 1'b1;
            chk("hold_audio_out_0", audio_out_0, hold_l);
            chk("hold_audio_out_1", audio_out_1, hold_r);
        end else if (hook_kind == 2) begin
            rst_n = 1'b0;
            #1;
            chk("midreset_audio_out_0", audio_out_0, 24'h0);
            chk("midreset_audio_out_1", audio_out_1, 24'h0);
            chk("midreset_strobes", {22'h0, err_out, valid_out}, 24'h0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        hook_bit  = -1;
        hook_kind = 0;
    endtask

    // One slot: ws changes on the first fall, MSB follows on the next fall,
    // padding and the discarded boundary bit are driven as 1
    task automatic send_slot(input logic ch, input logic [23:0] d, input int nbits,
                             input logic [23:0] hold_l, input logic [23:0] hold_r);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            sck_in = 1'b0;
            if (k == 0) ws_in = ch;
            sdo_in = (k >= 1 && k <= 24) ? d[24-k] : 1'b1;
            repeat (3) @(negedge clk);
            sck_in = 1'b1;
            last_rise_cyc = cyc;
            if (k == hook_bit) do_hook(hold_l, hold_r);
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};
        vecs[1] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};
        vecs[2] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
        vecs[3] = '{24'h000001, 24'hFFFFFE, 24'h000001, 24'hFFFFFE};
        vecs[4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        vecs[5] = '{24'hC3A51E, 24'h5A0F96, 24'hC3A51E, 24'h5A0F96};

        rst_n     = 1'b0;
        enable_in = 1'b0;
        sck_in    = 1'b0;
        ws_in     = 1'b0;
        sdo_in    = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_audio_out_0", audio_out_0, 24'h0);
        chk("reset_audio_out_1", audio_out_1, 24'h0);
        chk("reset_valid", {23'h0, valid_out}, 24'h0);
        chk("reset_err", {23'h0, err_out}, 24'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        enable_in = 1'b1;

        // Preamble right slot is only there to create the first 1->0 boundary
        send_slot(1'b1, 24'h0, 32, 24'h0, 24'h0);
        for (int i = 0; i < 6; i++) begin
            send_slot(1'b0, vecs[i].l_in, 32, 24'h0, 24'h0);
            push_exp(2'd1, vecs[i].exp_l, vecs[i].exp_r);
            send_slot(1'b1, vecs[i].r_in, 32, 24'h0, 24'h0);
        end

        // Short left slot: error at the 0->1 boundary, then full resync
        send_slot(1'b0, 24'h55AA55, 31, 24'h0, 24'h0);
        push_exp(2'd2, 24'h0, 24'h0);
        send_slot(1'b1, 24'h0F0F0F, 32, 24'h0, 24'h0);
        send_slot(1'b0, 24'h2468AC, 32, 24'h0, 24'h0);
        push_exp(2'd1, 24'h2468AC, 24'h13579B);
        send_slot(1'b1, 24'h13579B, 32, 24'h0, 24'h0);

        // Long right slot: error on the 32nd rise after the boundary
        send_slot(1'b0, 24'h111111, 32, 24'h0, 24'h0);
        push_exp(2'd2, 24'h0, 24'h0);
        send_slot(1'b1, 24'h222222, 33, 24'h0, 24'h0);
        send_slot(1'b0, 24'h333333, 32, 24'h0, 24'h0);
        push_exp(2'd1, 24'h333333, 24'h444444);
        send_slot(1'b1, 24'h444444, 32, 24'h0, 24'h0);

        // Enable dropped mid right slot: frame lost, outputs held
        send_slot(1'b0, 24'h5A5A5A, 32, 24'h0, 24'h0);
        hook_bit  = 12;
        hook_kind = 1;
        send_slot(1'b1, 24'hA5A5A5, 32, 24'h333333, 24'h444444);
        send_slot(1'b0, 24'h6789AB, 32, 24'h0, 24'h0);
        push_exp(2'd1, 24'h6789AB, 24'hFEDCBA);
        send_slot(1'b1, 24'hFEDCBA, 32, 24'h0, 24'h0);

        // Reset mid left slot: nothing until a SYNC plus a full frame
        hook_bit  = 10;
        hook_kind = 2;
        send_slot(1'b0, 24'h777777, 32, 24'h0, 24'h0);
        send_slot(1'b1, 24'h888888, 32, 24'h0, 24'h0);
        send_slot(1'b0, 24'h9ABCDE, 32, 24'h0, 24'h0);
        push_exp(2'd1, 24'h9ABCDE, 24'h0C0FFE);
        send_slot(1'b1, 24'h0C0FFE, 32, 24'h0, 24'h0);
        send_slot(1'b0, 24'h0, 32, 24'h0, 24'h0);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 24'(sb_q.size()), 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
